mem_lsu_stage: RTL

Handshaked load/store unit for the MEM stage of the 5-stage RISC-V pipeline. Replaces the single-cycle data-memory interface with a req/gnt/rvalid bus, so it tolerates variable memory latency. It stalls the pipeline while an access is in flight and captures WB-forwarded store data at launch. It also aligns and sign-extends load data, and reports bus errors and misaligned accesses.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/mem_lsu_stage_if.sv | 17 +
 rtl/mem_load_align.sv | 17 +
 rtl/mem_lsu_stage.sv | 104 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: LSU state encoding, load/store funct3 codes, byte-enable and alignment helpers
package riscv_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    function automatic logic [3:0] get_byte_enable(input logic [2:0] funct3, input logic [1:0] off);
        return funct3[1] ? 4'b1111 : funct3[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    endfunction
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return funct3[1] ? |off : funct3[0] & off[0];
    endfunction
endpackage

// File: rtl/mem_lsu_stage_if.sv
// mem_lsu_stage_if: req/gnt/rvalid data-memory bus
interface mem_lsu_stage_if #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
);
    logic            req;
    logic            we;
    logic [ALEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;
    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
    modport slave (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed lane of a read word and sign/zero-extends it
module mem_load_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] sh;
    always_comb begin
        sh = rdata >> {off, 3'b000};
        result = funct3[1] ? rdata
               : funct3[0] ? {{(XLEN-16){sh[15] & ~funct3[2]}}, sh[15:0]}
               : {{(XLEN-8){sh[7] & ~funct3[2]}}, sh[7:0]};
    end
endmodule

// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: handshaked MEM-stage load/store unit with stall, store-data forwarding and load alignment
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module mem_lsu_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ALEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_mem_valid,
    input  logic            ex_mem_mem_read,
    input  logic            ex_mem_mem_write,
    input  logic [2:0]      ex_mem_funct3,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] ex_mem_write_data,
    input  logic [4:0]      ex_mem_rs2,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_write_data,
    mem_lsu_stage_if.master dmem,
    output logic            mem_stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            access_fault,
    output logic            misalign
);
    lsu_state_e      state;
    logic [ALEN-1:0] addr_q;
    logic [2:0]      f3_q;
    logic            st_q;
    logic            start;
    logic            trap;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] aligned;

    mem_load_align #(.XLEN(XLEN)) u_align (
        .rdata  (dmem.rdata),
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .result (aligned)
    );

    always_comb begin
        start = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
        src = (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_mem_rs2) ? wb_write_data : ex_mem_write_data;
        lane_data = ex_mem_funct3[1] ? src
                  : ex_mem_funct3[0] ? {(XLEN/16){src[15:0]}}
                  : {(XLEN/8){src[7:0]}};
`ifdef MEM_MISALIGN_TRAP_EN
        trap = is_misaligned(ex_mem_funct3, ex_mem_alu_result[1:0]);
`else
        trap = 1'b0;
`endif
        mem_stall = (state == IDLE && start) || state == REQ || state == WAIT;
        dmem.req = state == REQ;
        dmem.we = dmem.req & st_q;
        dmem.be = dmem.req ? get_byte_enable(f3_q, addr_q[1:0]) : 4'b0000;
        dmem.addr = addr_q;
        dmem.wdata = wdata_q;
    end

    // Result flags are one-cycle pulses raised on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            f3_q         <= '0;
            st_q         <= 1'b0;
            wdata_q      <= '0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            misalign     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    addr_q   <= ex_mem_alu_result[ALEN-1:0];
                    f3_q     <= ex_mem_funct3;
                    st_q     <= ex_mem_mem_write;
                    wdata_q  <= lane_data;
                    misalign <= trap;
                    state    <= trap ? DONE : REQ;
                end
                REQ: if (dmem.gnt) begin
                    access_fault <= st_q & dmem.err;
                    state        <= st_q ? DONE : WAIT;
                end
                WAIT: if (dmem.rvalid) begin
                    load_valid   <= 1'b1;
                    access_fault <= dmem.err;
                    load_data    <= dmem.err ? '0 : aligned;
                    state        <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
